// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and FSM encoding for the register-file write arbiter.
package rf_write_arbiter_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_NUM_REGS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin grant: ptr=0 favours requester 0, ptr=1 favours requester 1.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] & (~valid[1] | ~ptr);
    assign grant[1] = valid[1] & (~valid[0] |  ptr);

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two write requesters onto one register-file write port and
// provides a clear-all sequence that zeroes every register.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk_n,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              init_req,
    output logic              init_done,
    output logic              busy,
    output logic              WE,
    output logic [ADDR_W-1:0] Waddr,
    output logic [DATA_W-1:0] Wdata
);

    // One extra bit so NUM_REGS = 2**ADDR_W reaches its last value without wrapping.
    localparam int              CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              init_done_q, init_done_d;
    logic [1:0]        grant;
    logic              arb_en;

    rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        init_done_d = 1'b0;
        arb_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_req) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else begin
                    arb_en = 1'b1;
                    if (grant[0]) begin
                        we_d    = 1'b1;
                        waddr_d = req0_addr;
                        wdata_d = req0_data;
                        ptr_d   = 1'b1;
                    end else if (grant[1]) begin
                        we_d    = 1'b1;
                        waddr_d = req1_addr;
                        wdata_d = req1_data;
                        ptr_d   = 1'b0;
                    end
                end
            end
            INIT: begin
                we_d    = 1'b1;
                waddr_d = cnt_q[ADDR_W-1:0];
                wdata_d = '0;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                init_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_n or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            init_done_q <= init_done_d;
        end
    end

    // Readies are masked by rst so nothing looks accepted while reset is held.
    assign req0_ready = arb_en & grant[0] & ~rst;
    assign req1_ready = arb_en & grant[1] & ~rst;
    assign busy       = (state_q != IDLE);
    assign init_done  = init_done_q;
    assign WE         = we_q;
    assign Waddr      = waddr_q;
    assign Wdata      = wdata_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: vector table for arbitration plus
// hand-written init, re-init and reset-abort sequences against an RF model.
module tb_rf_write_arbiter;

    logic        clk_n = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_addr, req1_addr;
    logic [15:0] req0_data, req1_data;
    logic        init_req;
    logic        init_done;
    logic        busy;
    logic        WE;
    logic [2:0]  Waddr;
    logic [15:0] Wdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf_mem [8];

    always #5 clk_n = ~clk_n;

    always @(posedge clk_n) begin
        if (WE) rf_mem[Waddr] <= Wdata;
    end

    rf_write_arbiter dut (
        .clk_n      (clk_n),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .init_req   (init_req),
        .init_done  (init_done),
        .busy       (busy),
        .WE         (WE),
        .Waddr      (Waddr),
        .Wdata      (Wdata)
    );

    typedef struct {
        logic        v0;
        logic [2:0]  a0;
        logic [15:0] d0;
        logic        v1;
        logic [2:0]  a1;
        logic [15:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [2:0]  waddr;
        logic [15:0] wdata;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Runs a full clear with both requesters valid; optionally re-pulses init_req
    // at cycle reinit_at, then checks the first grant after returning to IDLE.
    task automatic init_seq(input int reinit_at, input logic exp_g1,
                            input logic [2:0] exp_waddr, input logic [15:0] exp_wdata);
        int nwr = 0;
        int ndone = 0;
        int nbusy = 0;
        bit finished = 0;
        for (int c = 0; c < 20 && !finished; c++) begin
            @(negedge clk_n);
            init_req   = (c == 0) || (c == reinit_at);
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            #1;
            chk("init_r0", req0_ready, 0);
            chk("init_r1", req1_ready, 0);
            if (busy) nbusy++;
            @(posedge clk_n);
            #1;
            if (WE) begin
                chk("init_waddr", Waddr, nwr);
                chk("init_wdata", Wdata, 0);
                nwr++;
            end
            if (init_done) begin
                ndone++;
                finished = 1;
            end
        end
        chk("init_writes", nwr, 8);
        chk("init_done_pulses", ndone, 1);
        chk("init_busy_cycles", nbusy, 9);
        for (int a = 0; a < 8; a++) chk("rf_cleared", rf_mem[a], 0);
        @(negedge clk_n);
        init_req = 1'b0;
        #1;
        chk("resume_busy", busy, 0);
        chk("resume_r0", req0_ready, !exp_g1);
        chk("resume_r1", req1_ready, exp_g1);
        @(posedge clk_n);
        #1;
        chk("resume_done_low", init_done, 0);
        chk("resume_we", WE, 1);
        chk("resume_waddr", Waddr, exp_waddr);
        chk("resume_wdata", Wdata, exp_wdata);
        @(negedge clk_n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        int nwe;
        int ndone;
        bit found;

        vecs[0]  = '{1'b1, 3'd0, 16'h1111, 1'b1, 3'd1, 16'h2222, 1'b1, 1'b0, 1'b1, 3'd0, 16'h1111};
        vecs[1]  = '{1'b1, 3'd0, 16'h1111, 1'b1, 3'd1, 16'h2222, 1'b0, 1'b1, 1'b1, 3'd1, 16'h2222};
        vecs[2]  = '{1'b1, 3'd0, 16'h1111, 1'b1, 3'd1, 16'h2222, 1'b1, 1'b0, 1'b1, 3'd0, 16'h1111};
        vecs[3]  = '{1'b1, 3'd0, 16'h1111, 1'b1, 3'd1, 16'h2222, 1'b0, 1'b1, 1'b1, 3'd1, 16'h2222};
        vecs[4]  = '{1'b0, 3'd4, 16'h0f0f, 1'b0, 3'd5, 16'hf0f0, 1'b0, 1'b0, 1'b0, 3'd1, 16'h2222};
        vecs[5]  = '{1'b1, 3'd2, 16'h4444, 1'b0, 3'd5, 16'hf0f0, 1'b1, 1'b0, 1'b1, 3'd2, 16'h4444};
        vecs[6]  = '{1'b0, 3'd2, 16'h4444, 1'b1, 3'd5, 16'h5555, 1'b0, 1'b1, 1'b1, 3'd5, 16'h5555};
        vecs[7]  = '{1'b1, 3'd3, 16'h3333, 1'b1, 3'd4, 16'h6666, 1'b1, 1'b0, 1'b1, 3'd3, 16'h3333};
        vecs[8]  = '{1'b0, 3'd3, 16'h3333, 1'b0, 3'd4, 16'h6666, 1'b0, 1'b0, 1'b0, 3'd3, 16'h3333};
        vecs[9]  = '{1'b1, 3'd6, 16'haaaa, 1'b1, 3'd6, 16'hbbbb, 1'b0, 1'b1, 1'b1, 3'd6, 16'hbbbb};
        vecs[10] = '{1'b1, 3'd6, 16'haaaa, 1'b1, 3'd6, 16'hbbbb, 1'b1, 1'b0, 1'b1, 3'd6, 16'haaaa};
        vecs[11] = '{1'b0, 3'd6, 16'haaaa, 1'b0, 3'd6, 16'hbbbb, 1'b0, 1'b0, 1'b0, 3'd6, 16'haaaa};
        vecs[12] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 16'h7777, 1'b0, 1'b1, 1'b1, 3'd7, 16'h7777};

        // Reset state, with both requesters valid to confirm readies stay low.
        rst = 1'b1;
        init_req = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_addr = 3'd0;
        req1_addr = 3'd0;
        req0_data = 16'h0;
        req1_data = 16'h0;
        #2;
        chk("rst_we", WE, 0);
        chk("rst_waddr", Waddr, 0);
        chk("rst_wdata", Wdata, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_r0", req0_ready, 0);
        chk("rst_r1", req1_ready, 0);
        @(negedge clk_n);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk_n);
            req0_valid = vecs[i].v0;
            req0_addr  = vecs[i].a0;
            req0_data  = vecs[i].d0;
            req1_valid = vecs[i].v1;
            req1_addr  = vecs[i].a1;
            req1_data  = vecs[i].d1;
            #1;
            chk($sformatf("vec%0d_r0", i), req0_ready, vecs[i].r0);
            chk($sformatf("vec%0d_r1", i), req1_ready, vecs[i].r1);
            chk($sformatf("vec%0d_busy", i), busy, 0);
            @(posedge clk_n);
            #1;
            chk($sformatf("vec%0d_we", i), WE, vecs[i].we);
            chk($sformatf("vec%0d_waddr", i), Waddr, vecs[i].waddr);
            chk($sformatf("vec%0d_wdata", i), Wdata, vecs[i].wdata);
            chk($sformatf("vec%0d_done", i), init_done, 0);
        end
        @(negedge clk_n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Clear-all with both valid; pointer is 0 so requester 0 wins on resume.
        req0_addr = 3'd1;
        req0_data = 16'h1234;
        req1_addr = 3'd2;
        req1_data = 16'h5678;
        init_seq(-1, 1'b0, 3'd1, 16'h1234);

        // Write 0xdddd to addr 7 through requester 1 and see it land in the RF.
        @(negedge clk_n);
        req1_valid = 1'b1;
        req1_addr  = 3'd7;
        req1_data  = 16'hdddd;
        #1;
        chk("rf7_r1", req1_ready, 1);
        @(negedge clk_n);
        req1_valid = 1'b0;
        @(posedge clk_n);
        #1;
        chk("rf7_written", rf_mem[7], 16'hdddd);

        // Clear again with an extra init_req pulse mid-sequence.
        req1_addr = 3'd2;
        req1_data = 16'h5678;
        init_seq(3, 1'b0, 3'd1, 16'h1234);

        // Abort a clear with rst once the counter has reached 3.
        @(negedge clk_n);
        init_req   = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk_n);
        init_req = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk_n);
            #1;
            if (WE && Waddr == 3'd2) found = 1;
        end
        chk("abort_reached_cnt3", found, 1);
        @(negedge clk_n);
        rst = 1'b1;
        #1;
        chk("abort_we", WE, 0);
        chk("abort_waddr", Waddr, 0);
        chk("abort_busy", busy, 0);
        chk("abort_r0", req0_ready, 0);
        chk("abort_r1", req1_ready, 0);
        chk("abort_done", init_done, 0);
        @(negedge clk_n);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        nwe = 0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_n);
            #1;
            if (WE) nwe++;
            if (init_done) ndone++;
        end
        chk("abort_no_writes", nwe, 0);
        chk("abort_no_done", ndone, 0);
        chk("abort_idle", busy, 0);

        // Pointer must be back on requester 0 after reset.
        @(negedge clk_n);
        req0_valid = 1'b1;
        req0_addr  = 3'd5;
        req0_data  = 16'h9999;
        req1_valid = 1'b1;
        req1_addr  = 3'd6;
        req1_data  = 16'heeee;
        #1;
        chk("post_rst_r0", req0_ready, 1);
        chk("post_rst_r1", req1_ready, 0);
        @(posedge clk_n);
        #1;
        chk("post_rst_we", WE, 1);
        chk("post_rst_waddr", Waddr, 5);
        chk("post_rst_wdata", Wdata, 16'h9999);
        @(negedge clk_n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning register address width.
REQ-003 The block SHALL have parameter NUM_REGS, default 8, meaning number of registers cleared by the init sequence.
REQ-004 The block SHALL have port clk_n, input, 1 bit: the single clock; all state updates on the rising edge of clk_n.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: write request from requester 0 / 1.
REQ-007 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: request accepted this cycle.
REQ-008 The block SHALL have ports req0_addr and req1_addr, input, ADDR_W each: target register.
REQ-009 The block SHALL have ports req0_data and req1_data, input, DATA_W each: write data.
REQ-010 The block SHALL have port init_req, input, 1 bit: start a clear-all sequence.
REQ-011 The block SHALL have port init_done, output, 1 bit: one-cycle pulse when the clear completes.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have ports WE (output, 1), Waddr (output, ADDR_W) and Wdata (output, DATA_W): the register-file write port drive.

Function
REQ-014 The FSM SHALL have states IDLE, INIT and DONE.
REQ-015 In IDLE, when exactly one reqN_valid is high, reqN_ready SHALL be high in the same cycle (combinational).
REQ-016 In IDLE, when both requests are valid, the requester selected by the round-robin pointer SHALL be granted and the other SHALL have ready low.
REQ-017 After each grant, the pointer SHALL point to the non-granted requester; the pointer SHALL NOT change in cycles without a grant.
REQ-018 A transfer (valid and ready) SHALL produce WE=1, Waddr=addr and Wdata=data on the registered outputs in the next cycle (latency 1).
REQ-019 In any cycle with no transfer and no init write, WE SHALL be 0 in the following cycle, and Waddr/Wdata SHALL hold their previous values.
REQ-020 The arbiter SHALL NOT perform any address-collision filtering: consecutive writes to the same address are all issued, in grant order.
REQ-021 init_req high in IDLE SHALL move the FSM to INIT, and SHALL take priority over any valid request in that cycle: both readies low, no transfer.
REQ-022 In INIT, a counter SHALL run from 0 to NUM_REGS-1, producing one write per cycle: WE=1, Waddr=count, Wdata=0.
REQ-023 After the write of address NUM_REGS-1 is issued, the FSM SHALL enter DONE for one cycle, with init_done=1 and WE=0, then return to IDLE.
REQ-024 In INIT and DONE, both readies SHALL be 0, and init_req SHALL be ignored.
REQ-025 The counter SHALL be ADDR_W+1 bits wide so that NUM_REGS=2^ADDR_W terminates without wrap-around.

Reset
REQ-026 Asserting rst SHALL immediately set: state IDLE, pointer to requester 0, counter 0, WE=0, Waddr=0, Wdata=0, init_done=0.
REQ-027 Asserting rst during INIT SHALL abort the clear; no further init writes SHALL occur and init_done SHALL NOT pulse.
REQ-028 While rst is high, req0_ready, req1_ready and busy SHALL be 0.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding and the default DATA_W, ADDR_W and NUM_REGS constants.
REQ-030 The round-robin two-way arbiter SHALL be a sub-module named rr_arb2 (inputs: valid pair, pointer; outputs: grant pair); the FSM and output registers SHALL stay in the top module.

Verification
REQ-031 The bench SHALL cover: req0 alone, addr 3'b010, data 16'h4444 -> req0_ready=1 that cycle; next cycle WE=1, Waddr=2, Wdata=16'h4444.
REQ-032 The bench SHALL cover: after reset, both valid for 4 cycles (req0 16'h1111 to addr 0, req1 16'h2222 to addr 1) -> grants alternate 0,1,0,1 and the WE stream matches.
REQ-033 The bench SHALL cover: init_req with both requests valid -> no ready; 8 cycles of WE=1 with Waddr 0..7 and Wdata 16'h0000; then init_done for 1 cycle; busy for 9 cycles; then arbitration resumes.
REQ-034 The bench SHALL cover: rst asserted at init count 3 -> WE=0 immediately, no init_done, state IDLE after release.
REQ-035 The bench SHALL cover: init_req pulsed again during INIT -> sequence length unchanged (8 writes, 1 init_done).
REQ-036 The bench SHALL cover: the RF model connected, writes 16'hdddd to addr 7 via req1, then init -> RF reads back 16'h0000 on all addresses.
